// File: rtl/ecc_pkg.sv
// Shared SECDED definitions: codeword width encoding, Hsiao H-matrix columns and
// per-width field geometry used by ecc_syndrome and ecc_decoder.
package ecc_pkg;

    localparam int AMBA_W = 32;
    localparam int SYN_W  = 6;

    typedef logic [SYN_W-1:0]  syn_t;
    typedef logic [AMBA_W-1:0] word_t;

    typedef enum logic [1:0] {
        CW_SMALL = 2'b00,
        CW_MED   = 2'b01,
        CW_LARGE = 2'b10
    } cw_width_e;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'd0,
        ERR_CORR   = 2'd1,
        ERR_UNCORR = 2'd2
    } err_e;

    // Column k is the syndrome of a flip of codeword bit k. Parity bits sit in the
    // LSBs as unit vectors; data columns all have odd weight (3 or 5).
    localparam syn_t H_S [8] = '{
        6'h01, 6'h02, 6'h04, 6'h08,
        6'h0B, 6'h0D, 6'h0E, 6'h07
    };

    localparam syn_t H_M [16] = '{
        6'h01, 6'h02, 6'h04, 6'h08, 6'h10,
        6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19, 6'h1A, 6'h1C,
        6'h1F
    };

    localparam syn_t H_L [32] = '{
        6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20,
        6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19, 6'h1A, 6'h1C,
        6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C, 6'h31, 6'h32, 6'h34, 6'h38,
        6'h1F, 6'h2F, 6'h37, 6'h3B, 6'h3D, 6'h3E
    };

    typedef struct packed {
        cw_width_e width;
        word_t     cw;
        syn_t      syn;
        word_t     match;
    } stage1_t;

    function automatic cw_width_e decode_width(logic [1:0] code);
        case (code)
            2'b00:   return CW_SMALL;
            2'b01:   return CW_MED;
            default: return CW_LARGE;
        endcase
    endfunction

    function automatic int par_w(cw_width_e w);
        case (w)
            CW_SMALL: return 4;
            CW_MED:   return 5;
            default:  return 6;
        endcase
    endfunction

    function automatic int data_w(cw_width_e w);
        case (w)
            CW_SMALL: return 4;
            CW_MED:   return 11;
            default:  return 26;
        endcase
    endfunction

    function automatic int data_lsb(cw_width_e w);
        return par_w(w);
    endfunction

    function automatic word_t width_mask(cw_width_e w);
        case (w)
            CW_SMALL: return 32'h0000_00FF;
            CW_MED:   return 32'h0000_FFFF;
            default:  return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic word_t extract_data(word_t cw, cw_width_e w);
        word_t mask;
        mask = (word_t'(1) << data_w(w)) - word_t'(1);
        return (cw >> data_lsb(w)) & mask;
    endfunction

endpackage

// File: rtl/ecc_syndrome.sv
// ecc_syndrome: combinational syndrome generator for 8/16/32-bit codewords plus a
// one-hot match of the selected syndrome against the H columns of that width.
module ecc_syndrome
    import ecc_pkg::*;
(
    input  word_t     cw,
    input  cw_width_e width,
    output syn_t      syn,
    output word_t     match
);

    syn_t        syn_s;
    syn_t        syn_m;
    syn_t        syn_l;
    logic [7:0]  match_s;
    logic [15:0] match_m;
    logic [31:0] match_l;

    // NOTE: every always_comb target is given a default before any conditional write, so no latch can be inferred.
    always_comb begin
        syn_s = '0;
        syn_m = '0;
        syn_l = '0;
        for (int k = 0; k < 8; k++)  if (cw[k]) syn_s ^= H_S[k];
        for (int k = 0; k < 16; k++) if (cw[k]) syn_m ^= H_M[k];
        for (int k = 0; k < 32; k++) if (cw[k]) syn_l ^= H_L[k];
    end

    always_comb begin
        match_s = '0;
        match_m = '0;
        match_l = '0;
        for (int k = 0; k < 8; k++)  match_s[k] = (syn_s == H_S[k]);
        for (int k = 0; k < 16; k++) match_m[k] = (syn_m == H_M[k]);
        for (int k = 0; k < 32; k++) match_l[k] = (syn_l == H_L[k]);
    end

    always_comb begin
        syn   = syn_l;
        match = match_l;
        case (width)
            CW_SMALL: begin
                syn   = syn_s;
                match = {24'd0, match_s};
            end
            CW_MED: begin
                syn   = syn_m;
                match = {16'd0, match_m};
            end
            default: begin
                syn   = syn_l;
                match = match_l;
            end
        endcase
        // A clean word must never point at a column.
        if (syn == '0) match = '0;
    end

endmodule

// File: rtl/ecc_decoder.sv
// ecc_decoder: two-stage SECDED decoder for right-aligned 8/16/32-bit codewords.
// Define ECC_DEC_ERR_CNT_EN to build the saturating corrected/uncorrectable counters.
module ecc_decoder
    import ecc_pkg::*;
#(
    parameter int AMBA_WORD = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 VALID_IN,
    input  logic [1:0]           CODEWORD_WIDTH,
    input  logic [AMBA_WORD-1:0] CW_IN,
    output logic [AMBA_WORD-1:0] DEC_OUT,
    output logic [1:0]           NUM_OF_ERRORS,
    output logic                 VALID_OUT,
    input  logic                 CNT_CLR,
    output logic [CNT_WIDTH-1:0] CORR_CNT,
    output logic [CNT_WIDTH-1:0] UNCORR_CNT
);

    cw_width_e in_width;
    word_t     in_cw;
    syn_t      in_syn;
    word_t     in_match;

    assign in_width = decode_width(CODEWORD_WIDTH);
    assign in_cw    = CW_IN & width_mask(in_width);

    ecc_syndrome u_syndrome (
        .cw    (in_cw),
        .width (in_width),
        .syn   (in_syn),
        .match (in_match)
    );

    logic    s1_valid;
    stage1_t s1;

    // NOTE: sequential state is written with <= so every flop samples pre-edge values regardless of block order.
    // NOTE: the data registers are reset along with the valids, so a reset leaves no stale codeword behind.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1       <= '0;
        end else begin
            s1_valid <= VALID_IN;
            if (VALID_IN) begin
                s1 <= '{width: in_width, cw: in_cw, syn: in_syn, match: in_match};
            end
        end
    end

    err_e  s2_err;
    word_t s2_data;

    // With no column hit the match vector is zero, so the XOR leaves raw data in place.
    always_comb begin
        s2_err = ERR_NONE;
        if (s1.syn != '0) begin
            s2_err = (s1.match != '0) ? ERR_CORR : ERR_UNCORR;
        end
        s2_data = extract_data(s1.cw ^ s1.match, s1.width);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            VALID_OUT     <= 1'b0;
            DEC_OUT       <= '0;
            NUM_OF_ERRORS <= 2'b00;
        end else begin
            VALID_OUT <= s1_valid;
            if (s1_valid) begin
                DEC_OUT       <= s2_data;
                NUM_OF_ERRORS <= s2_err;
            end
        end
    end

`ifdef ECC_DEC_ERR_CNT_EN
    logic corr_hit;
    logic uncorr_hit;

    assign corr_hit   = s1_valid && (s2_err == ERR_CORR);
    assign uncorr_hit = s1_valid && (s2_err == ERR_UNCORR);

    // Counters advance on the same edge that presents the beat; a clear on that edge wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            CORR_CNT   <= '0;
            UNCORR_CNT <= '0;
        end else if (CNT_CLR) begin
            CORR_CNT   <= '0;
            UNCORR_CNT <= '0;
        end else begin
            if (corr_hit && (CORR_CNT != '1)) begin
                CORR_CNT <= CORR_CNT + CNT_WIDTH'(1);
            end
            if (uncorr_hit && (UNCORR_CNT != '1)) begin
                UNCORR_CNT <= UNCORR_CNT + CNT_WIDTH'(1);
            end
        end
    end
`else
    logic unused_cnt_clr;

    assign unused_cnt_clr = CNT_CLR;
    assign CORR_CNT       = '0;
    assign UNCORR_CNT     = '0;
`endif

endmodule

// File: tb/tb_ecc_decoder.sv
// Self-checking bench for ecc_decoder: randomized and directed beats against a
// behavioural SECDED model with a per-cycle output compare.
module tb_ecc_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid_in;
    logic [1:0]  cw_width;
    logic [31:0] cw_in;
    logic        cnt_clr;
    logic [31:0] dec_out;
    logic [1:0]  num_err;
    logic        valid_out;
    logic [15:0] corr_cnt;
    logic [15:0] uncorr_cnt;

    always #5 clk = ~clk;

    ecc_decoder dut (
        .clk            (clk),
        .rst            (rst),
        .VALID_IN       (valid_in),
        .CODEWORD_WIDTH (cw_width),
        .CW_IN          (cw_in),
        .DEC_OUT        (dec_out),
        .NUM_OF_ERRORS  (num_err),
        .VALID_OUT      (valid_out),
        .CNT_CLR        (cnt_clr),
        .CORR_CNT       (corr_cnt),
        .UNCORR_CNT     (uncorr_cnt)
    );

    typedef struct {
        int          due;
        logic [31:0] data;
        logic [1:0]  num;
    } exp_t;

    exp_t        exp_q[$];
    int          vectors    = 0;
    int          miscompares = 0;
    int          cyc        = 0;
    logic [31:0] last_data  = '0;
    logic [1:0]  last_num   = '0;
    logic [15:0] corr_m     = '0;
    logic [15:0] uncorr_m   = '0;
    logic        clr_seen   = 1'b0;
    logic [5:0]  hcol [3][32];

    always @(posedge clk) begin
        cyc      = cyc + 1;
        clr_seen = cnt_clr;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int ncw(input logic [1:0] w);
        case (w)
            2'd0:    return 8;
            2'd1:    return 16;
            default: return 32;
        endcase
    endfunction

    function automatic int npar(input logic [1:0] w);
        case (w)
            2'd0:    return 4;
            2'd1:    return 5;
            default: return 6;
        endcase
    endfunction

    function automatic int widx(input logic [1:0] w);
        return (w == 2'd3) ? 2 : int'(w);
    endfunction

    // 8b columns follow the published parity equations; wider codes list the
    // odd-weight columns by weight, then by value.
    function automatic logic [5:0] col(input logic [1:0] w, input int k);
        int         np;
        int         cnt;
        logic [5:0] c;
        np = npar(w);
        c  = '0;
        if (k >= ncw(w)) return '0;
        if (k < np) return 6'(1 << k);
        if (w == 2'd0) begin
            c[0] = (k == 7) || (k == 5) || (k == 4);
            c[1] = (k == 7) || (k == 6) || (k == 4);
            c[2] = (k == 7) || (k == 6) || (k == 5);
            c[3] = (k == 6) || (k == 5) || (k == 4);
            return c;
        end
        cnt = 0;
        for (int wt = 3; wt <= 5; wt += 2) begin
            for (int v = 1; v < (1 << np); v++) begin
                if ($countones(v) == wt) begin
                    if (cnt == k - np) return 6'(v);
                    cnt++;
                end
            end
        end
        return '0;
    endfunction

    function automatic logic [5:0] syndrome(input logic [31:0] cw, input logic [1:0] w);
        logic [5:0] s;
        s = '0;
        for (int k = 0; k < ncw(w); k++) if (cw[k]) s ^= hcol[widx(w)][k];
        return s;
    endfunction

    function automatic logic [31:0] encode(input logic [31:0] d, input logic [1:0] w);
        logic [31:0] cw;
        cw = d << npar(w);
        return cw | 32'(syndrome(cw, w));
    endfunction

    task automatic model_decode(input logic [1:0] w, input logic [31:0] raw,
                                output logic [31:0] d, output logic [1:0] n);
        int          nc;
        logic [31:0] cw;
        logic [5:0]  s;
        nc = ncw(w);
        cw = (nc == 32) ? raw : (raw & ((32'd1 << nc) - 32'd1));
        s  = syndrome(cw, w);
        n  = (s == '0) ? 2'd0 : 2'd2;
        if (s != '0) begin
            for (int k = 0; k < nc; k++) begin
                if (hcol[widx(w)][k] == s) begin
                    cw[k] = ~cw[k];
                    n     = 2'd1;
                end
            end
        end
        d = (cw >> npar(w)) & ((32'd1 << (nc - npar(w))) - 32'd1);
    endtask

    // ---------------- drivers ----------------
    task automatic beat(input logic [1:0] w, input logic [31:0] cw, input logic clr);
        exp_t        e;
        logic [31:0] d;
        logic [1:0]  n;
        @(posedge clk);
        #1;
        valid_in = 1'b1;
        cw_width = w;
        cw_in    = cw;
        cnt_clr  = clr;
        model_decode(w, cw, d, n);
        e.due  = cyc + 2;
        e.data = d;
        e.num  = n;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n, input logic clr);
        repeat (n) begin
            @(posedge clk);
            #1;
            valid_in = 1'b0;
            cw_in    = $urandom;
            cw_width = 2'($urandom_range(0, 3));
            cnt_clr  = clr;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        valid_in  = 1'b0;
        cnt_clr   = 1'b0;
        exp_q.delete();
        last_data = '0;
        last_num  = '0;
        corr_m    = '0;
        uncorr_m  = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        exp_t e;
        logic hit;
        if (!rst) begin
            check("rst_valid_out", 32'(valid_out), 32'd0);
            check("rst_dec_out", dec_out, 32'd0);
            check("rst_num_err", 32'(num_err), 32'd0);
            check("rst_corr_cnt", 32'(corr_cnt), 32'd0);
            check("rst_uncorr_cnt", 32'(uncorr_cnt), 32'd0);
        end else begin
            hit = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            if (hit) begin
                e         = exp_q.pop_front();
                last_data = e.data;
                last_num  = e.num;
            end
`ifdef ECC_DEC_ERR_CNT_EN
            if (clr_seen) begin
                corr_m   = '0;
                uncorr_m = '0;
            end else if (hit) begin
                if (e.num == 2'd1 && corr_m != 16'hFFFF) corr_m++;
                if (e.num == 2'd2 && uncorr_m != 16'hFFFF) uncorr_m++;
            end
`endif
            check("valid_out", 32'(valid_out), 32'(hit));
            check("dec_out", dec_out, last_data);
            check("num_err", 32'(num_err), 32'(last_num));
            check("corr_cnt", 32'(corr_cnt), 32'(corr_m));
            check("uncorr_cnt", 32'(uncorr_cnt), 32'(uncorr_m));
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] d;
        logic [31:0] cw;
        logic [1:0]  n;
        logic [1:0]  w;
        int          nc;
        int          p1;
        int          p2;
        int          nerr;

        for (int wi = 0; wi < 3; wi++) begin
            for (int k = 0; k < 32; k++) hcol[wi][k] = col(2'(wi), k);
        end

        valid_in = 1'b0;
        cw_width = 2'd0;
        cw_in    = '0;
        cnt_clr  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Hand-computed anchors for the model.
        check("model_enc_b", encode(32'hB, 2'd0), 32'h0000_00B1);
        model_decode(2'd0, 32'h0000_00F1, d, n);
        check("model_f1_data", d, 32'hB);
        check("model_f1_num", 32'(n), 32'd1);
        model_decode(2'd0, 32'h0000_00F0, d, n);
        check("model_f0_data", d, 32'hF);
        check("model_f0_num", 32'(n), 32'd2);
        model_decode(2'd0, 32'h0000_00B0, d, n);
        check("model_b0_data", d, 32'hB);
        check("model_b0_num", 32'(n), 32'd1);
        check("model_h16_top", 32'(hcol[1][15]), 32'h1F);
        check("model_h32_top", 32'(hcol[2][31]), 32'h3E);

        // Directed 8b cases.
        beat(2'd0, 32'h0000_00B1, 1'b0);
        beat(2'd0, 32'h0000_00F1, 1'b0);
        beat(2'd0, 32'h0000_00B0, 1'b0);
        beat(2'd0, 32'h0000_00F0, 1'b0);
        idle(3, 1'b0);

        // Back-to-back mixed widths with every single-bit flip position.
        beat(2'd2, 32'h0, 1'b0);
        cw = encode($urandom & 32'h7FF, 2'd1);
        for (int k = 0; k < 16; k++) beat(2'd1, cw ^ (32'd1 << k), 1'b0);
        cw = encode($urandom & 32'hF, 2'd0);
        for (int k = 0; k < 8; k++) beat(2'd0, cw ^ (32'd1 << k), 1'b0);
        cw = encode($urandom & 32'h3FF_FFFF, 2'd3);
        beat(2'd3, cw ^ 32'h8000_0000, 1'b0);
        idle(3, 1'b0);

        // Randomized beats: widths, 0/1/2 errors, junk above the width, gaps, clears.
        for (int i = 0; i < 400; i++) begin
            w    = 2'($urandom_range(0, 3));
            nc   = ncw(w);
            d    = $urandom & ((32'd1 << (nc - npar(w))) - 32'd1);
            cw   = encode(d, w);
            nerr = $urandom_range(0, 2);
            p1   = $urandom_range(0, nc - 1);
            p2   = (p1 + $urandom_range(1, nc - 1)) % nc;
            if (nerr >= 1) cw[p1] = ~cw[p1];
            if (nerr == 2) cw[p2] = ~cw[p2];
            if (nc < 32) cw = cw | ($urandom << nc);
            beat(w, cw, ($urandom_range(0, 15) == 0));
            if ($urandom_range(0, 3) == 0) idle(1, 1'b0);
        end
        idle(3, 1'b0);

`ifdef ECC_DEC_ERR_CNT_EN
        idle(1, 1'b1);
        idle(2, 1'b0);
        for (int i = 0; i < 65534 + 3; i++) beat(2'd0, 32'h0000_00F1, 1'b0);
        idle(3, 1'b0);
        check("corr_saturated", 32'(corr_cnt), 32'h0000_FFFF);
`endif

        // Clear on the same edge that presents a corrected beat.
        beat(2'd0, 32'h0000_00F1, 1'b0);
        beat(2'd0, 32'h0000_00B1, 1'b1);
        idle(3, 1'b0);
        check("corr_clr_wins", 32'(corr_cnt), 32'd0);

        // Reset while a beat sits in stage 1: it must never appear.
        beat(2'd0, 32'h0000_00F0, 1'b0);
        do_reset();
        idle(4, 1'b0);
        check("post_rst_valid", 32'(valid_out), 32'd0);
        check("post_rst_dec", dec_out, 32'd0);
        beat(2'd0, 32'h0000_00B1, 1'b0);
        idle(4, 1'b0);
        check("post_rst_beat", dec_out, 32'hB);
        check("drain", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
